// File: rtl/game_pkg.sv
// Shared game definitions: state encoding seen by the duck block, sprite/screen
// geometry and a saturating score adder.
package game_pkg;

    typedef enum logic [2:0] {
        TITLE = 3'b000,
        START = 3'b001,
        FLY   = 3'b010,
        PAUSE = 3'b011,
        FALL  = 3'b100,
        OVER  = 3'b101
    } game_state_t;

    localparam int SPRITE_SIZE = 64;
    localparam int SCREEN_W    = 640;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/game_control_if.sv
// Bundle between the game sequencer, the player inputs and the duck/HUD blocks.
// The master side is game_control; the slave side is its surroundings.
interface game_control_if #(
    parameter int N_DUCKS = 10
);
    import game_pkg::*;

    logic                frame_clk;
    logic                start;
    logic                trigger;
    logic [9:0]          aim_x;
    logic [9:0]          aim_y;
    logic [9:0]          duck_x;
    logic [9:0]          duck_y;
    logic                flew_away;
    logic                duck_ded_done;

    game_state_t         state;
    logic                shot;
    logic                new_round;
    logic [1:0]          shots_left;
    logic [3:0]          duck_num;
    logic [3:0]          hits;
    logic [N_DUCKS-1:0]  hit_mask;
    logic [7:0]          round;
    logic [15:0]         score;

    modport master (
        input  frame_clk, start, trigger, aim_x, aim_y,
               duck_x, duck_y, flew_away, duck_ded_done,
        output state, shot, new_round, shots_left, duck_num,
               hits, hit_mask, round, score
    );

    modport slave (
        output frame_clk, start, trigger, aim_x, aim_y,
               duck_x, duck_y, flew_away, duck_ded_done,
        input  state, shot, new_round, shots_left, duck_num,
               hits, hit_mask, round, score
    );

endinterface

// File: rtl/game_control_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-Clk
// pulse on each rising edge of the synchronised signal.
module sync_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic din,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbour; = here would collapse the chain.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/game_control.sv
// Round/turn sequencer for the duck game: owns the game state, ammo, duck
// index, per-round hits, round number and score, and pulses shot/new_round.
module game_control
    import game_pkg::*;
#(
    parameter int DUCKS_PER_ROUND = 10,
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int MIN_HITS        = 6,
    parameter int PAUSE_FRAMES    = 90,
    parameter int HIT_SIZE        = SPRITE_SIZE,
    parameter int POINTS          = 500
) (
    input logic            Clk,
    input logic            Reset,
    game_control_if.master bus
);

    localparam int FCW = $clog2(PAUSE_FRAMES + 1);

    game_state_t state_q, state_d;

    logic                       frame_tick, trig_p, start_p;
    logic [FCW-1:0]             frame_cnt_q, frame_cnt_d;
    logic [1:0]                 shots_left_q, shots_left_d;
    logic [3:0]                 duck_num_q, duck_num_d;
    logic [3:0]                 hits_q, hits_d;
    logic [DUCKS_PER_ROUND-1:0] hit_mask_q, hit_mask_d;
    logic [7:0]                 round_q, round_d;
    logic [15:0]                score_q, score_d;
    logic                       shot_q, shot_d;
    logic                       new_round_q, new_round_d;

    logic        fire, hit, in_x, in_y, frame_done, last_duck, round_won, begin_game;
    logic [10:0] box_x_end, box_y_end;

    sync_edge u_frame_sync (.Clk(Clk), .Reset(Reset), .din(bus.frame_clk), .pulse(frame_tick));
    sync_edge u_trig_sync  (.Clk(Clk), .Reset(Reset), .din(bus.trigger),   .pulse(trig_p));
    sync_edge u_start_sync (.Clk(Clk), .Reset(Reset), .din(bus.start),     .pulse(start_p));

    // Box ends are formed at 11 bits so a duck near the right/bottom edge cannot wrap.
    assign box_x_end  = {1'b0, bus.duck_x} + 11'(HIT_SIZE);
    assign box_y_end  = {1'b0, bus.duck_y} + 11'(HIT_SIZE);
    assign in_x       = (bus.aim_x >= bus.duck_x) && ({1'b0, bus.aim_x} < box_x_end);
    assign in_y       = (bus.aim_y >= bus.duck_y) && ({1'b0, bus.aim_y} < box_y_end);

    assign fire       = (state_q == FLY) && trig_p && (shots_left_q != 2'd0);
    assign hit        = fire && in_x && in_y;
    assign frame_done = frame_tick && (frame_cnt_q == FCW'(PAUSE_FRAMES - 1));
    assign last_duck  = (duck_num_q == 4'(DUCKS_PER_ROUND - 1));
    assign round_won  = (hits_q >= 4'(MIN_HITS));
    assign begin_game = start_p && ((state_q == TITLE) || (state_q == OVER));

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= TITLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TITLE, OVER: if (start_p)          state_d = START;
            START:       if (frame_done)       state_d = FLY;
            FLY: begin
                if (hit)                       state_d = FALL;
                else if (bus.flew_away)        state_d = PAUSE;
            end
            FALL:        if (bus.duck_ded_done) state_d = PAUSE;
            PAUSE: begin
                if (frame_done)                state_d = (!last_duck || round_won) ? START : OVER;
            end
            default:                           state_d = TITLE;
        endcase
    end

    // NOTE: every variable gets its hold value first so no path through the
    // block leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        shots_left_d = shots_left_q;
        duck_num_d   = duck_num_q;
        hits_d       = hits_q;
        hit_mask_d   = hit_mask_q;
        round_d      = round_q;
        score_d      = score_q;
        shot_d       = 1'b0;
        new_round_d  = 1'b0;

        // The pause counter restarts on every entry into a timed state.
        if ((state_d == START || state_d == PAUSE) && state_d != state_q) begin
            frame_cnt_d = '0;
        end else if (frame_tick && (state_q == START || state_q == PAUSE) && !frame_done) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        if (state_d == START && state_q != START) begin
            shots_left_d = 2'(SHOTS_PER_DUCK);
        end

        if (begin_game) begin
            round_d     = 8'd1;
            score_d     = '0;
            hits_d      = '0;
            hit_mask_d  = '0;
            duck_num_d  = '0;
            new_round_d = 1'b1;
        end

        if (fire) begin
            shots_left_d = shots_left_q - 2'd1;
        end

        if (hit) begin
            shot_d               = 1'b1;
            hits_d               = hits_q + 4'd1;
            hit_mask_d[duck_num_q] = 1'b1;
            score_d              = sat_add16(score_q, 16'(POINTS));
        end

        if (state_q == PAUSE && frame_done) begin
            if (!last_duck) begin
                duck_num_d = duck_num_q + 4'd1;
            end else if (round_won) begin
                round_d     = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
                hits_d      = '0;
                hit_mask_d  = '0;
                duck_num_d  = '0;
                new_round_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt_q  <= '0;
            shots_left_q <= '0;
            duck_num_q   <= '0;
            hits_q       <= '0;
            hit_mask_q   <= '0;
            round_q      <= '0;
            score_q      <= '0;
            shot_q       <= 1'b0;
            new_round_q  <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            shots_left_q <= shots_left_d;
            duck_num_q   <= duck_num_d;
            hits_q       <= hits_d;
            hit_mask_q   <= hit_mask_d;
            round_q      <= round_d;
            score_q      <= score_d;
            shot_q       <= shot_d;
            new_round_q  <= new_round_d;
        end
    end

    always_comb begin
        bus.state      = state_q;
        bus.shot       = shot_q;
        bus.new_round  = new_round_q;
        bus.shots_left = shots_left_q;
        bus.duck_num   = duck_num_q;
        bus.hits       = hits_q;
        bus.hit_mask   = hit_mask_q;
        bus.round      = round_q;
        bus.score      = score_q;
    end

endmodule

// File: tb/tb_game_control.sv
// Randomised bench for game_control: a game-rules model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_game_control;

    localparam int N = 10;
    localparam int S_TITLE = 0, S_START = 1, S_FLY = 2, S_PAUSE = 3, S_FALL = 4, S_OVER = 5;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    game_control_if #(.N_DUCKS(N)) bus ();

    game_control #(.DUCKS_PER_ROUND(N)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    bit noise    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- game-rules model ----------------
    bit         model_valid = 1'b0;
    int         m_state, m_ammo, m_duck, m_hits, m_round, m_score, m_wait;
    bit         m_shot, m_nr;
    bit [N-1:0] m_mask;
    bit         f0, f1, f2, t0, t1, t2, s0, s1, s2;   // recent samples of each async input

    task automatic m_enter_start();
        m_state = S_START;
        m_ammo  = 3;
        m_wait  = 90;
    endtask

    task automatic m_new_game();
        m_round = 1; m_score = 0; m_hits = 0; m_mask = '0; m_duck = 0;
        m_nr = 1'b1;
        m_enter_start();
    endtask

    always @(posedge Clk) begin : model
        bit f_ev, t_ev, s_ev, fire, hit;
        int ax, ay, dx, dy;
        if (Reset) begin
            m_state = S_TITLE; m_ammo = 0; m_duck = 0; m_hits = 0; m_round = 0;
            m_score = 0; m_wait = 0; m_mask = '0; m_shot = 0; m_nr = 0;
            {f0, f1, f2, t0, t1, t2, s0, s1, s2} = '0;
            model_valid = 1'b1;
        end else begin
            // A level change is seen by the sequencer two samples after it was sampled.
            f_ev = f1 && !f2;
            t_ev = t1 && !t2;
            s_ev = s1 && !s2;
            m_shot = 0;
            m_nr   = 0;
            case (m_state)
                S_TITLE, S_OVER: if (s_ev) m_new_game();
                S_START: if (f_ev) begin
                    m_wait--;
                    if (m_wait == 0) m_state = S_FLY;
                end
                S_FLY: begin
                    ax = int'(bus.aim_x); ay = int'(bus.aim_y);
                    dx = int'(bus.duck_x); dy = int'(bus.duck_y);
                    fire = t_ev && m_ammo > 0;
                    hit  = fire && ax >= dx && ax < dx + 64 && ay >= dy && ay < dy + 64;
                    if (fire) m_ammo--;
                    if (hit) begin
                        m_shot = 1;
                        m_hits++;
                        m_mask[m_duck] = 1'b1;
                        m_score = (m_score + 500 > 65535) ? 65535 : m_score + 500;
                        m_state = S_FALL;
                    end else if (bus.flew_away) begin
                        m_state = S_PAUSE;
                        m_wait  = 90;
                    end
                end
                S_FALL: if (bus.duck_ded_done) begin
                    m_state = S_PAUSE;
                    m_wait  = 90;
                end
                S_PAUSE: if (f_ev) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        if (m_duck < N - 1) begin
                            m_duck++;
                            m_enter_start();
                        end else if (m_hits >= 6) begin
                            if (m_round < 255) m_round++;
                            m_hits = 0; m_mask = '0; m_duck = 0; m_nr = 1;
                            m_enter_start();
                        end else begin
                            m_state = S_OVER;
                        end
                    end
                end
                default: m_state = S_TITLE;
            endcase
            f2 = f1; f1 = f0; f0 = bus.frame_clk;
            t2 = t1; t1 = t0; t0 = bus.trigger;
            s2 = s1; s1 = s0; s0 = bus.start;
        end
    end

    always @(negedge Clk) begin
        if (model_valid) begin
            check("state",      32'(bus.state),      32'(m_state));
            check("shot",       32'(bus.shot),       32'(m_shot));
            check("new_round",  32'(bus.new_round),  32'(m_nr));
            check("shots_left", 32'(bus.shots_left), 32'(m_ammo));
            check("duck_num",   32'(bus.duck_num),   32'(m_duck));
            check("hits",       32'(bus.hits),       32'(m_hits));
            check("hit_mask",   32'(bus.hit_mask),   32'(m_mask));
            check("round",      32'(bus.round),      32'(m_round));
            check("score",      32'(bus.score),      32'(m_score));
        end
    end

    // ---------------- stimulus helpers ----------------
    int dx_r, dy_r;

    task automatic cycle();
        @(negedge Clk);
        if ($urandom_range(0, 3) != 0) bus.frame_clk = ~bus.frame_clk;
        if (noise) bus.trigger = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_state(input int s, input string name);
        int n = 0;
        while (32'(bus.state) != s && n < 3000) begin
            cycle();
            n++;
        end
        if (n == 3000) check({name, "_timeout"}, 32'(bus.state), 32'(s));
    endtask

    task automatic wait_new_round(input string name);
        int n = 0;
        while (bus.new_round !== 1'b1 && n < 3000) begin
            cycle();
            n++;
        end
        if (n == 3000) check({name, "_timeout"}, 32'(bus.new_round), 32'd1);
    endtask

    task automatic fire();
        bus.trigger = 1'b1;
        repeat (3) cycle();
        bus.trigger = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic place_duck();
        dx_r = $urandom_range(1, 575);
        dy_r = $urandom_range(1, 415);
        bus.duck_x = 10'(dx_r);
        bus.duck_y = 10'(dy_r);
    endtask

    task automatic aim_hit();
        int k = $urandom_range(0, 2);
        bus.aim_x = 10'(dx_r + ((k == 0) ? 0 : (k == 1) ? 63 : $urandom_range(0, 63)));
        bus.aim_y = 10'(dy_r + ((k == 1) ? 0 : (k == 0) ? 63 : $urandom_range(0, 63)));
    endtask

    task automatic aim_miss();
        case ($urandom_range(0, 3))
            0: begin bus.aim_x = 10'(dx_r + 64); bus.aim_y = 10'(dy_r + 10); end
            1: begin bus.aim_x = 10'(dx_r - 1);  bus.aim_y = 10'(dy_r + 10); end
            2: begin bus.aim_x = 10'(dx_r + 10); bus.aim_y = 10'(dy_r + 64); end
            default: begin bus.aim_x = 10'(dx_r + 20); bus.aim_y = 10'(dy_r - 1); end
        endcase
    endtask

    task automatic pause_noise();
        noise = 1'b1;
        repeat (20) cycle();
        noise = 1'b0;
        bus.trigger = 1'b0;
        cycle();
    endtask

    task automatic finish_fall();
        noise = 1'b1;
        repeat ($urandom_range(0, 8)) cycle();
        bus.duck_ded_done = 1'b1;
        cycle();
        bus.duck_ded_done = 1'b0;
        pause_noise();
    endtask

    task automatic play_duck(input bit want_hit);
        int nmiss;
        wait_state(S_FLY, "to_fly");
        place_duck();
        if (want_hit) begin
            if ($urandom_range(0, 1) == 1) begin aim_miss(); fire(); end
            aim_hit();
            fire();
            wait_state(S_FALL, "to_fall");
            finish_fall();
        end else begin
            nmiss = $urandom_range(0, 3);
            repeat (nmiss) begin aim_miss(); fire(); end
            if (nmiss == 3) begin aim_hit(); fire(); end   // no ammo left: must not count
            bus.flew_away = 1'b1;
            cycle();
            bus.flew_away = 1'b0;
            wait_state(S_PAUSE, "to_pause");
            pause_noise();
        end
    endtask

    // ---------------- directed + random scenario ----------------
    initial begin
        int exp_ammo[4] = '{2, 1, 0, 0};
        bit plan1[7]    = '{1, 0, 1, 1, 0, 0, 1};
        int r;

        bus.frame_clk = 0; bus.start = 0; bus.trigger = 0;
        bus.aim_x = 0; bus.aim_y = 0; bus.duck_x = 0; bus.duck_y = 0;
        bus.flew_away = 0; bus.duck_ded_done = 0;

        repeat (3) cycle();
        check("rst_state", 32'(bus.state), S_TITLE);
        check("rst_round", 32'(bus.round), 0);
        check("rst_shots", 32'(bus.shots_left), 0);
        Reset = 1'b0;
        repeat (2) cycle();

        // Start edge: new_round visible three samples later.
        bus.start = 1'b1;
        repeat (3) cycle();
        check("start_nr",    32'(bus.new_round), 1);
        check("start_state", 32'(bus.state), S_START);
        check("start_round", 32'(bus.round), 1);
        bus.start = 1'b0;
        cycle();
        check("start_nr_1clk", 32'(bus.new_round), 0);
        wait_state(S_FLY, "first_fly");
        check("fly_ammo", 32'(bus.shots_left), 3);

        // Duck 0: clean hit.
        bus.duck_x = 200; bus.duck_y = 100; bus.aim_x = 230; bus.aim_y = 150;
        bus.trigger = 1'b1;
        repeat (3) cycle();
        check("hit_shot",  32'(bus.shot), 1);
        check("hit_hits",  32'(bus.hits), 1);
        check("hit_score", 32'(bus.score), 500);
        check("hit_mask",  32'(bus.hit_mask), 1);
        check("hit_state", 32'(bus.state), S_FALL);
        check("hit_ammo",  32'(bus.shots_left), 2);
        bus.trigger = 1'b0;
        cycle();
        check("hit_shot_1clk", 32'(bus.shot), 0);
        repeat (4) cycle();
        bus.duck_ded_done = 1'b1;
        cycle();
        bus.duck_ded_done = 1'b0;
        check("ded_to_pause", 32'(bus.state), S_PAUSE);

        // Duck 1: four misses, ammo runs dry, then flies away.
        wait_state(S_FLY, "duck1_fly");
        bus.aim_x = 0; bus.aim_y = 0;
        for (int i = 0; i < 4; i++) begin
            bus.trigger = 1'b1;
            repeat (3) cycle();
            check("miss_ammo",  32'(bus.shots_left), 32'(exp_ammo[i]));
            check("miss_shot",  32'(bus.shot), 0);
            check("miss_state", 32'(bus.state), S_FLY);
            bus.trigger = 1'b0;
            repeat (2) cycle();
        end
        bus.flew_away = 1'b1;
        cycle();
        bus.flew_away = 1'b0;
        check("flew_pause", 32'(bus.state), S_PAUSE);

        // Duck 2: hit at the right edge of the box in the same cycle as flew_away.
        wait_state(S_FLY, "duck2_fly");
        bus.duck_x = 300; bus.duck_y = 200; bus.aim_x = 363; bus.aim_y = 200;
        bus.trigger = 1'b1;
        repeat (2) cycle();
        bus.flew_away = 1'b1;
        cycle();
        check("coinc_shot",  32'(bus.shot), 1);
        check("coinc_state", 32'(bus.state), S_FALL);
        bus.flew_away = 1'b0;
        bus.trigger   = 1'b0;
        cycle();
        check("coinc_stay", 32'(bus.state), S_FALL);
        finish_fall();

        // Ducks 3..9: four more hits gives six, enough to advance.
        for (int i = 0; i < 7; i++) play_duck(plan1[i]);
        wait_new_round("round2");
        check("r2_round", 32'(bus.round), 2);
        check("r2_hits",  32'(bus.hits), 0);
        check("r2_mask",  32'(bus.hit_mask), 0);
        check("r2_state", 32'(bus.state), S_START);
        check("r2_score", 32'(bus.score), 3000);

        // Round 2: exactly five hits, so the game ends.
        r = $urandom_range(0, 1);
        for (int i = 0; i < N; i++) play_duck(1'((i + r) % 2));
        wait_state(S_OVER, "to_over");
        check("over_score", 32'(bus.score), 5500);
        check("over_hits",  32'(bus.hits), 5);
        check("over_round", 32'(bus.round), 2);

        // Restart from OVER, then reset while a duck is falling.
        bus.start = 1'b1;
        repeat (3) cycle();
        check("restart_nr",    32'(bus.new_round), 1);
        check("restart_score", 32'(bus.score), 0);
        bus.start = 1'b0;
        wait_state(S_FLY, "restart_fly");
        place_duck();
        aim_hit();
        fire();
        wait_state(S_FALL, "reset_fall");
        Reset = 1'b1;
        cycle();
        check("rstfall_state", 32'(bus.state), S_TITLE);
        check("rstfall_score", 32'(bus.score), 0);
        check("rstfall_hits",  32'(bus.hits), 0);
        check("rstfall_round", 32'(bus.round), 0);
        Reset = 1'b0;
        bus.duck_ded_done = 1'b1;
        cycle();
        bus.duck_ded_done = 1'b0;
        repeat (3) cycle();
        check("rstfall_ded_ignored", 32'(bus.state), S_TITLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
